// File: rtl/mesh_noc_pkg.sv
// mesh_noc_pkg: shared port encoding, packet field helpers and XY routing rule for the mesh NoC.
package mesh_noc_pkg;
  typedef enum logic [2:0] {P_N, P_E, P_S, P_W, P_L} port_e;
  localparam int NPORT = 5;
  function automatic int pkt_w(int data_w, int rows, int cols);
    return data_w + $clog2(rows) + $clog2(cols);
  endfunction
  function automatic int pkt_row(logic [63:0] p, int pw, int rw);
    return int'((p >> (pw - rw)) & ((64'd1 << rw) - 64'd1));
  endfunction
  function automatic int pkt_col(logic [63:0] p, int pw, int rw, int cw);
    return int'((p >> (pw - rw - cw)) & ((64'd1 << cw) - 64'd1));
  endfunction
  function automatic port_e xy_route(int dst_row, int dst_col, int my_row, int my_col);
    return dst_col > my_col ? P_E : dst_col < my_col ? P_W :
           dst_row > my_row ? P_S : dst_row < my_row ? P_N : P_L;
  endfunction
endpackage

// File: rtl/mesh_xy_router.sv
// mesh_xy_router: five input FIFOs, XY route at each head, round-robin arbiter per output, crossbar.
module mesh_xy_router
  import mesh_noc_pkg::*;
#(
  parameter int ROW_N        = 3,
  parameter int COL_M        = 3,
  parameter int ROW_IDX      = 0,
  parameter int COL_IDX      = 0,
  parameter int FIFO_DEPTH_W = 3,
  parameter int PCKT_DATA_W  = 8,
  parameter int PACKET_W     = pkt_w(PCKT_DATA_W, ROW_N, COL_M)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PACKET_W-1:0] in_pckt [NPORT],
  input  logic [NPORT-1:0]    in_wren,
  output logic [NPORT-1:0]    in_full,
  output logic                ovrflw,
  output logic [PACKET_W-1:0] out_pckt [NPORT],
  output logic [NPORT-1:0]    out_wren,
  input  logic [NPORT-1:0]    out_full
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_W;
  localparam int RW = $clog2(ROW_N);
  localparam int CW = $clog2(COL_M);
  logic [PACKET_W-1:0] mem [NPORT][DEPTH];
  logic [PACKET_W-1:0] head [NPORT];
  logic [FIFO_DEPTH_W-1:0] wr_ptr [NPORT];
  logic [FIFO_DEPTH_W-1:0] rd_ptr [NPORT];
  logic [FIFO_DEPTH_W:0] cnt [NPORT];
  logic [2:0] rr_ptr [NPORT];
  logic [2:0] gnt_idx [NPORT];
  port_e route [NPORT];
  logic [NPORT-1:0] push, pop;
  // full comes only from the registered count, so no combinational path crosses a hop
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      head[i]    = mem[i][rd_ptr[i]];
      in_full[i] = cnt[i] == (FIFO_DEPTH_W+1)'(DEPTH);
      route[i]   = xy_route(pkt_row(64'(head[i]), PACKET_W, RW),
                            pkt_col(64'(head[i]), PACKET_W, RW, CW), ROW_IDX, COL_IDX);
    end
  end
  assign push = in_wren & ~in_full;
  // search starts at the pointer; the first requesting input wins
  always_comb begin
    int idx;
    idx = 0;
    pop = '0;
    for (int o = 0; o < NPORT; o++) begin
      out_wren[o] = 1'b0;
      out_pckt[o] = '0;
      gnt_idx[o]  = rr_ptr[o];
      for (int k = 0; k < NPORT; k++) begin
        idx = (int'(rr_ptr[o]) + k) % NPORT;
        if (!out_wren[o] && !out_full[o] && cnt[idx] != '0 && route[idx] == port_e'(o)) begin
          out_wren[o] = 1'b1;
          out_pckt[o] = head[idx];
          gnt_idx[o]  = 3'(idx);
          pop[idx]    = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NPORT; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
        rr_ptr[i] <= '0;
      end
      ovrflw <= 1'b0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        wr_ptr[i] <= wr_ptr[i] + FIFO_DEPTH_W'(push[i]);
        rd_ptr[i] <= rd_ptr[i] + FIFO_DEPTH_W'(pop[i]);
        cnt[i]    <= cnt[i] + (FIFO_DEPTH_W+1)'(push[i]) - (FIFO_DEPTH_W+1)'(pop[i]);
        if (out_wren[i]) rr_ptr[i] <= gnt_idx[i] == 3'(NPORT-1) ? 3'd0 : gnt_idx[i] + 3'd1;
      end
      ovrflw <= in_wren[P_L] && in_full[P_L];
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NPORT; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= in_pckt[i];
  end
endmodule

// File: rtl/mesh_xy_noc.sv
// mesh_xy_noc: ROW_N x COL_M mesh of XY routers with flat-vector resource ports.
module mesh_xy_noc
  import mesh_noc_pkg::*;
#(
  parameter int ROW_N        = 3,
  parameter int COL_M        = 3,
  parameter int FIFO_DEPTH_W = 3,
  parameter int PCKT_DATA_W  = 8,
  localparam int PACKET_W    = pkt_w(PCKT_DATA_W, ROW_N, COL_M),
  localparam int NODES       = ROW_N * COL_M
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NODES*PACKET_W-1:0] rsc_pckt_i,
  input  logic [NODES-1:0]          rsc_wren_i,
  output logic [NODES-1:0]          noc_full_o,
  output logic [NODES-1:0]          noc_ovrflw_o,
  output logic [NODES*PACKET_W-1:0] noc_pckt_o,
  output logic [NODES-1:0]          noc_wren_o,
  input  logic [NODES-1:0]          rsc_full_i,
  input  logic [NODES-1:0]          rsc_ovrflw_i
);
  logic [PACKET_W-1:0] in_pckt [NODES][NPORT];
  logic [PACKET_W-1:0] out_pckt [NODES][NPORT];
  logic [NPORT-1:0] in_wren [NODES];
  logic [NPORT-1:0] in_full [NODES];
  logic [NPORT-1:0] out_wren [NODES];
  logic [NPORT-1:0] out_full [NODES];
  for (genvar r = 0; r < ROW_N; r++) begin : g_row
    for (genvar c = 0; c < COL_M; c++) begin : g_col
      localparam int K  = r * COL_M + c;
      // edge nodes point at themselves; the constant guard ties those links off
      localparam int KN = r > 0 ? K - COL_M : K;
      localparam int KE = c < COL_M - 1 ? K + 1 : K;
      localparam int KS = r < ROW_N - 1 ? K + COL_M : K;
      localparam int KW = c > 0 ? K - 1 : K;
      assign in_pckt[K][P_N] = r > 0 ? out_pckt[KN][P_S] : '0;
      assign in_pckt[K][P_E] = c < COL_M - 1 ? out_pckt[KE][P_W] : '0;
      assign in_pckt[K][P_S] = r < ROW_N - 1 ? out_pckt[KS][P_N] : '0;
      assign in_pckt[K][P_W] = c > 0 ? out_pckt[KW][P_E] : '0;
      assign in_pckt[K][P_L] = rsc_pckt_i[K*PACKET_W +: PACKET_W];
      assign in_wren[K] = {rsc_wren_i[K], c > 0 && out_wren[KW][P_E], r < ROW_N - 1 && out_wren[KS][P_N],
                           c < COL_M - 1 && out_wren[KE][P_W], r > 0 && out_wren[KN][P_S]};
      assign out_full[K] = {rsc_full_i[K], c > 0 && in_full[KW][P_E], r < ROW_N - 1 && in_full[KS][P_N],
                            c < COL_M - 1 && in_full[KE][P_W], r > 0 && in_full[KN][P_S]};
      assign noc_full_o[K] = in_full[K][P_L];
      assign noc_wren_o[K] = out_wren[K][P_L];
      assign noc_pckt_o[K*PACKET_W +: PACKET_W] = out_pckt[K][P_L];
      mesh_xy_router #(
        .ROW_N(ROW_N), .COL_M(COL_M), .ROW_IDX(r), .COL_IDX(c),
        .FIFO_DEPTH_W(FIFO_DEPTH_W), .PCKT_DATA_W(PCKT_DATA_W), .PACKET_W(PACKET_W)
      ) u_router (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_pckt(in_pckt[K]), .in_wren(in_wren[K]), .in_full(in_full[K]),
        .ovrflw(noc_ovrflw_o[K]),
        .out_pckt(out_pckt[K]), .out_wren(out_wren[K]), .out_full(out_full[K])
      );
    end
  end
endmodule

// File: tb/tb_mesh_xy_noc.sv
// tb_mesh_xy_noc: directed latency/backpressure cases plus random traffic against a delivery scoreboard.
module tb_mesh_xy_noc;
  localparam int NN = 9;
  localparam int PW = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NN*PW-1:0] rsc_pckt, noc_pckt;
  logic [NN-1:0] rsc_wren, noc_full, noc_ovrflw, noc_wren, rsc_full, rsc_ovrflw;
  int checks = 0;
  int failures = 0;
  typedef struct {int src; int dst; logic [PW-1:0] pkt;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  mesh_xy_noc dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rsc_pckt_i(rsc_pckt), .rsc_wren_i(rsc_wren),
    .noc_full_o(noc_full), .noc_ovrflw_o(noc_ovrflw),
    .noc_pckt_o(noc_pckt), .noc_wren_o(noc_wren),
    .rsc_full_i(rsc_full), .rsc_ovrflw_i(rsc_ovrflw)
  );
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [PW-1:0] mk(int r, int c, int d);
    return {2'(r), 2'(c), 8'(d)};
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic put(int k, logic [PW-1:0] p, bit expect_out = 1'b1);
    rsc_pckt[k*PW +: PW] = p;
    rsc_wren[k] = 1'b1;
    if (expect_out) sb.push_back('{src: k, dst: int'(p[11:10]) * 3 + int'(p[9:8]), pkt: p});
  endtask
  task automatic drain(int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step;
      n++;
    end
    check("drain_left", sb.size(), 0);
  endtask
  // monitor: every ejected packet must be expected at that node and in order per source
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NN; k++) begin
        if (noc_wren[k]) begin
          logic [PW-1:0] p;
          int idx;
          bit bad_order;
          p = noc_pckt[k*PW +: PW];
          idx = -1;
          bad_order = 1'b0;
          check($sformatf("wren_while_full[%0d]", k), int'(rsc_full[k]), 0);
          for (int j = 0; j < sb.size(); j++)
            if (idx < 0 && sb[j].dst == k && sb[j].pkt == p) idx = j;
          checks++;
          if (idx < 0) begin
            failures++;
            $display("FAIL deliver[%0d]: got unexpected packet %03h, required a queued packet", k, p);
          end else begin
            for (int j = 0; j < idx; j++)
              if (sb[j].src == sb[idx].src && sb[j].dst == k) bad_order = 1'b1;
            if (bad_order) begin
              failures++;
              $display("FAIL order[%0d]: got %03h from src %0d ahead of an older packet", k, p, sb[idx].src);
            end
            sb.delete(idx);
          end
        end
      end
    end
  end
  initial begin
    int sent, n, seq;
    rsc_pckt = '0;
    rsc_wren = '0;
    rsc_full = '0;
    rsc_ovrflw = '0;
    repeat (2) step;
    check("rst_wren", int'(noc_wren), 0);
    check("rst_pckt", int'(noc_pckt != '0), 0);
    rst_n = 1'b1;
    repeat (2) step;
    check("idle_wren", int'(noc_wren), 0);
    check("idle_full", int'(noc_full), 0);
    check("idle_ovrflw", int'(noc_ovrflw), 0);
    check("idle_pckt", int'(noc_pckt != '0), 0);
    // corner to corner: four hops
    put(0, mk(2, 2, 'hA5));
    step;
    rsc_wren = '0;
    for (int j = 0; j <= 5; j++) begin
      check($sformatf("t2_wren8_e%0d", j), int'(noc_wren[8]), int'(j == 4));
      if (j == 4) check("t2_data", int'(noc_pckt[8*PW +: PW]), 'hAA5);
      step;
    end
    drain(50);
    // local loopback
    put(4, mk(1, 1, 'h3C));
    step;
    rsc_wren = '0;
    check("t3_wren4", int'(noc_wren[4]), 1);
    check("t3_data", int'(noc_pckt[4*PW +: PW]), 'h53C);
    step;
    check("t3_wren4_off", int'(noc_wren[4]), 0);
    drain(50);
    // fill the local FIFO behind a blocked resource, then overflow it
    rsc_full[4] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      put(4, mk(1, 1, i), i < 9);
      step;
      check($sformatf("t4_full_w%0d", i), int'(noc_full[4]), int'(i >= 8));
      check($sformatf("t4_ovrflw_w%0d", i), int'(noc_ovrflw[4]), int'(i == 9));
    end
    rsc_wren = '0;
    step;
    check("t4_ovrflw_pulse_end", int'(noc_ovrflw[4]), 0);
    check("t4_full_held", int'(noc_full[4]), 1);
    check("t4_blocked", int'(noc_wren[4]), 0);
    rsc_full[4] = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      #2;
      check($sformatf("t4_release_c%0d", j), int'(noc_wren[4]), int'(j < 8));
      step;
    end
    drain(50);
    // four neighbours converge on node 4 in the same cycle
    put(1, mk(1, 1, 'h51));
    put(3, mk(1, 1, 'h53));
    put(5, mk(1, 1, 'h55));
    put(7, mk(1, 1, 'h57));
    step;
    rsc_wren = '0;
    for (int j = 0; j <= 7; j++) begin
      check($sformatf("t5_wren4_e%0d", j), int'(noc_wren[4]), int'(j >= 1 && j <= 4));
      check($sformatf("t5_ovrflw_e%0d", j), int'(noc_ovrflw != '0), 0);
      step;
    end
    drain(50);
    // stream with a flapping sink
    sent = 0;
    n = 0;
    while (sent < 20 && n < 400) begin
      rsc_full[6] = 1'($urandom_range(0, 1));
      if (!noc_full[2]) begin
        put(2, mk(2, 0, 'h60 + sent));
        sent++;
      end
      step;
      rsc_wren = '0;
      n++;
    end
    check("t6_sent", sent, 20);
    for (int j = 0; j < 30; j++) begin
      rsc_full[6] = 1'($urandom_range(0, 1));
      step;
    end
    rsc_full = '0;
    drain(200);
    // random all-to-all traffic under random backpressure
    seq = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      for (int k = 0; k < NN; k++) begin
        rsc_full[k] = $urandom_range(0, 3) == 0;
        if (seq < 200 && $urandom_range(0, 2) == 0 && !noc_full[k]) begin
          put(k, mk($urandom_range(0, 2), $urandom_range(0, 2), seq));
          seq++;
        end
      end
      step;
      rsc_wren = '0;
    end
    rsc_full = '0;
    drain(600);
    check("final_ovrflw", int'(noc_ovrflw), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
